// File: rtl/trdb_reg_apb.sv
// APB register block for the trace debugger: CTRL/CFG/STATUS/FILTER registers and the trace FSM.
// Optional filter channels are built only when TRDB_REG_FILTER_EN is defined.
module trdb_reg_apb #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [ADDR_W-1:0]      paddr_i,
  input  logic [31:0]            pwdata_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  input  logic                   flush_done_i,
  output logic                   trace_enable_o,
  output logic                   trace_activated_o,
  output logic                   nocontext_o,
  output logic                   notime_o,
  output logic                   delta_address_o,
  output logic                   encoder_mode_o,
  output logic [6:0]             configuration_o,
  output logic [NUM_CH*32-1:0]   filter_addr_o
);

  localparam int WW = ADDR_W - 2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ACTIVE = 4'd1,
    S_DRAIN  = 4'd2
  } state_e;

  state_e     state_q, state_d;
  logic       enable_q, enable_d;
  logic [3:0] cfg_q, cfg_d;
  logic       cfg_err_q, cfg_err_d;

  logic [WW-1:0] widx;
  logic acc, wr, rd;
  logic sel_ctrl, sel_cfg, sel_stat, sel_filt;
  logic prot_err, activated;
  logic [31:0] rdata;
  logic unused_ok;

  assign widx     = paddr_i[ADDR_W-1:2];
  assign acc      = psel_i & penable_i;
  assign wr       = acc & pwrite_i;
  assign rd       = acc & ~pwrite_i;
  assign sel_ctrl = (widx == WW'(0));
  assign sel_cfg  = (widx == WW'(1));
  assign sel_stat = (widx == WW'(2));
  assign unused_ok = ^{paddr_i[1:0], pwdata_i};

`ifdef TRDB_REG_FILTER_EN
  logic [NUM_CH-1:0][31:0] filter_q, filter_d;
  logic [NUM_CH-1:0]       filt_hit;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) filt_hit[i] = (widx == WW'(4 + i));
  end
  assign sel_filt = |filt_hit;

  always_comb begin
    filter_d = filter_q;
    for (int i = 0; i < NUM_CH; i++)
      if (wr && filt_hit[i] && state_q == S_IDLE) filter_d[i] = pwdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) filter_q <= '0;
    else         filter_q <= filter_d;
  end

  assign filter_addr_o = filter_q;
`else
  assign sel_filt      = 1'b0;
  assign filter_addr_o = '0;
`endif

  // Configuration is frozen while tracing runs; attempts are flagged, not applied.
  assign prot_err  = wr & (sel_cfg | sel_filt) & (state_q != S_IDLE);
  assign activated = (state_q == S_ACTIVE) || (state_q == S_DRAIN);

  always_comb begin
    enable_d  = enable_q;
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;
    state_d   = state_q;
    if (wr && sel_ctrl) enable_d = pwdata_i[0];
    if (wr && sel_cfg && state_q == S_IDLE) cfg_d = pwdata_i[3:0];
    if (wr && sel_stat && pwdata_i[1]) cfg_err_d = 1'b0;
    if (prot_err) cfg_err_d = 1'b1;
    case (state_q)
      // Start uses the enable value carried in the same write; stop beats start.
      S_IDLE:   if (wr && sel_ctrl && pwdata_i[1] && !pwdata_i[2] && pwdata_i[0])
                  state_d = S_ACTIVE;
      S_ACTIVE: if (wr && sel_ctrl && (pwdata_i[2] || !pwdata_i[0]))
                  state_d = S_DRAIN;
      S_DRAIN:  if (flush_done_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      enable_q  <= 1'b0;
      cfg_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_ctrl) rdata = {31'b0, enable_q};
      if (sel_cfg)  rdata = {28'b0, cfg_q};
      if (sel_stat) rdata = {26'b0, state_q, cfg_err_q, activated};
`ifdef TRDB_REG_FILTER_EN
      for (int i = 0; i < NUM_CH; i++)
        if (filt_hit[i]) rdata = filter_q[i];
`endif
    end
  end

  assign prdata_o          = rdata;
  assign pready_o          = 1'b1;
  assign pslverr_o         = prot_err;
  assign trace_enable_o    = enable_q;
  assign trace_activated_o = activated;
  assign nocontext_o       = cfg_q[0];
  assign notime_o          = cfg_q[1];
  assign delta_address_o   = cfg_q[2];
  assign encoder_mode_o    = 1'b0;
  assign configuration_o   = {cfg_q[2], cfg_q[3], 5'b0};

endmodule

// File: tb/tb_trdb_reg_apb.sv
// Directed bench for trdb_reg_apb: register map, write protection, trace FSM and reset behaviour.
module tb_trdb_reg_apb;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 psel_i, penable_i, pwrite_i;
  logic [ADDR_W-1:0]    paddr_i;
  logic [31:0]          pwdata_i;
  logic [31:0]          prdata_o;
  logic                 pready_o, pslverr_o;
  logic                 flush_done_i;
  logic                 trace_enable_o, trace_activated_o;
  logic                 nocontext_o, notime_o, delta_address_o, encoder_mode_o;
  logic [6:0]           configuration_o;
  logic [NUM_CH*32-1:0] filter_addr_o;

  int passed = 0;
  int total  = 0;
  logic        last_err;
  logic [31:0] last_rd;

  trdb_reg_apb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o),
    .flush_done_i(flush_done_i),
    .trace_enable_o(trace_enable_o), .trace_activated_o(trace_activated_o),
    .nocontext_o(nocontext_o), .notime_o(notime_o), .delta_address_o(delta_address_o),
    .encoder_mode_o(encoder_mode_o), .configuration_o(configuration_o),
    .filter_addr_o(filter_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1 last_err = pslverr_o;
    @(posedge clk_i);
    #1 psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] a);
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1 begin last_rd = prdata_o; last_err = pslverr_o; end
    @(posedge clk_i);
    #1 psel_i = 1'b0; penable_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; flush_done_i = 1'b0;
    psel_i = 1'b1; penable_i = 1'b1; pwrite_i = 1'b0; paddr_i = 8'h08; pwdata_i = '0;
    #12;
    chk("rst_prdata", prdata_o, 0);
    chk("rst_pready", pready_o, 1);
    chk("rst_pslverr", pslverr_o, 0);
    chk("rst_outs", {trace_enable_o, trace_activated_o, encoder_mode_o, configuration_o}, 0);
    chk("rst_filter", filter_addr_o, 0);
    psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;

    apb_read(8'h00); chk("rd_ctrl0", last_rd, 0); chk("rd_ctrl0_err", last_err, 0);
    apb_read(8'h04); chk("rd_cfg0", last_rd, 0);
    apb_read(8'h08); chk("rd_stat0", last_rd, 0);
    chk("cfg_vec0", configuration_o, 7'b0);

    apb_write(8'h04, 32'h5);
    chk("cfg_bits", {nocontext_o, notime_o, delta_address_o}, 3'b101);
    chk("cfg_vec5", configuration_o, 7'b1000000);
    apb_read(8'h04); chk("rd_cfg5", last_rd, 5);

    apb_write(8'h00, 32'h3);
    chk("act_start", trace_activated_o, 1);
    chk("en_start", trace_enable_o, 1);
    apb_read(8'h08); chk("stat_active", last_rd, 32'h5);

    apb_write(8'h04, 32'hF); chk("prot_err", last_err, 1);
    apb_read(8'h04); chk("cfg_kept", last_rd, 5);
    apb_read(8'h08); chk("stat_cfgerr", last_rd, 32'h7);
    apb_write(8'h08, 32'h2);
    apb_read(8'h08); chk("stat_w1c", last_rd, 32'h5);

    apb_write(8'h00, 32'h3);
    apb_read(8'h08); chk("start_in_active", last_rd, 32'h5);

    apb_write(8'h00, 32'h5);
    apb_read(8'h08); chk("stat_drain", last_rd, 32'h9);
    repeat (3) begin
      @(posedge clk_i); #1 chk("drain_hold", trace_activated_o, 1);
    end
    @(negedge clk_i) flush_done_i = 1'b1;
    @(posedge clk_i); #1 chk("drain_exit", trace_activated_o, 0);
    flush_done_i = 1'b0;
    apb_read(8'h08); chk("stat_idle", last_rd, 0);
    apb_read(8'h00); chk("ctrl_selfclr", last_rd, 1);

    apb_write(8'h00, 32'h7);
    apb_read(8'h08); chk("start_stop_idle", last_rd, 0);
    apb_write(8'h00, 32'h2);
    apb_read(8'h08); chk("start_no_en", last_rd, 0);
    apb_read(8'h00); chk("ctrl_en0", last_rd, 0);

    apb_write(8'h0C, 32'hFFFF_FFFF); chk("unmap_wr_err", last_err, 0);
    apb_read(8'h0C); chk("unmap_rd", last_rd, 0);

    // flush_done already high when DRAIN is entered via enable=0
    apb_write(8'h00, 32'h3);
    flush_done_i = 1'b1;
    apb_write(8'h00, 32'h0);
    chk("drain_1cyc_in", trace_activated_o, 1);
    @(posedge clk_i); #1 chk("drain_1cyc_out", trace_activated_o, 0);
    flush_done_i = 1'b0;

`ifdef TRDB_REG_FILTER_EN
    apb_write(8'h14, 32'hDEAD_BEEF);
    chk("filt1_out", filter_addr_o[63:32], 32'hDEAD_BEEF);
    chk("filt0_out", filter_addr_o[31:0], 0);
    apb_read(8'h14); chk("filt1_rd", last_rd, 32'hDEAD_BEEF);
    apb_write(8'h18, 32'h1234_5678); chk("filt_oob_err", last_err, 0);
    apb_read(8'h18); chk("filt_oob_rd", last_rd, 0);
    apb_write(8'h00, 32'h3);
    apb_write(8'h10, 32'hAAAA_5555); chk("filt_prot_err", last_err, 1);
    chk("filt0_kept", filter_addr_o[31:0], 0);
`else
    apb_write(8'h14, 32'hDEAD_BEEF);
    chk("nofilt_out", filter_addr_o, 0);
    apb_read(8'h14); chk("nofilt_rd", last_rd, 0);
    apb_write(8'h00, 32'h3);
    apb_write(8'h10, 32'hAAAA_5555); chk("nofilt_prot", last_err, 0);
    apb_read(8'h08); chk("nofilt_noerr", last_rd, 32'h5);
`endif

    // reset in the middle of DRAIN, without flush_done
    apb_write(8'h04, 32'h0);
    apb_write(8'h00, 32'h5);
    chk("pre_rst_drain", trace_activated_o, 1);
    @(negedge clk_i) rst_ni = 1'b0;
    #1 chk("rst_mid_drain", trace_activated_o, 0);
    chk("rst_mid_en", trace_enable_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    apb_read(8'h08); chk("stat_after_rst", last_rd, 0);
    apb_read(8'h04); chk("cfg_after_rst", last_rd, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
